// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: ALUOP codes, FSM states and op-class helpers.
package alu_pkg;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } alu_state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops (FORWARD/ADD/AND/OR/SUB) with carry/borrow.
// Any other op code passes A through with carry 0, which the top uses for zero-length shifts.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext      = '0;
    result_o = a_i;
    carry_o  = 1'b0;
    case (op_i)
      ALU_FWD: result_o = b_i;
      ALU_ADD: begin
        ext      = {1'b0, a_i} + {1'b0, b_i};
        result_o = ext[WIDTH-1:0];
        carry_o  = ext[WIDTH];
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SUB: begin
        // The top bit of the widened difference is the unsigned borrow (A < B).
        ext      = {1'b0, a_i} - {1'b0, b_i};
        result_o = ext[WIDTH-1:0];
        carry_o  = ext[WIDTH];
      end
      default: begin
        result_o = a_i;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: one-cycle ops through alu_core, bit-serial SLL/SRA and shift-add MUL.
// state | meaning
// IDLE  | waiting for START
// RUN   | iterative op stepping one bit per edge, BUSY high
// FIN   | result and flags just written, DONE high; a new START is accepted here
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic [2:0]       aluop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] aluresult_o,
  output logic             zero_o,
  output logic             carry_o
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_AS_OP = WIDTH'(WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  alu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] mp_q;
  logic [WIDTH-1:0] acc_q;
  logic             cbit_q;
  logic             lost_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic [CW-1:0]    shamt;
  logic [CW-1:0]    load_cnt;
  logic             iter_op;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] mp_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] fin_res;
  logic             cbit_d;
  logic             lost_d;
  logic [WIDTH:0]   sum_ext;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (operand1_i),
    .b_i      (operand2_i),
    .op_i     (aluop_i),
    .result_o (core_res),
    .carry_o  (core_carry)
  );

  always_comb begin
    shamt    = (operand2_i >= W_AS_OP) ? CNT_FULL : CW'(operand2_i);
    iter_op  = (aluop_i == ALU_MUL) || (is_shift_op(aluop_i) && (shamt != '0));
    load_cnt = (aluop_i == ALU_MUL) ? CNT_FULL : shamt;
  end

  // One iteration step. For MUL, cbit tracks sticky overflow: a product >= 2^WIDTH shows up
  // either as a carry out of the accumulator or as an added multiplicand that already lost bits.
  always_comb begin
    sh_d    = sh_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    cbit_d  = cbit_q;
    lost_d  = lost_q;
    sum_ext = '0;
    case (op_q)
      ALU_SLL: begin
        cbit_d = sh_q[WIDTH-1];
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
      end
      ALU_SRA: begin
        cbit_d = sh_q[0];
        sh_d   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      end
      default: begin
        sum_ext = {1'b0, acc_q} + {1'b0, sh_q};
        if (mp_q[0]) begin
          acc_d  = sum_ext[WIDTH-1:0];
          cbit_d = cbit_q | sum_ext[WIDTH] | lost_q;
        end
        lost_d = lost_q | sh_q[WIDTH-1];
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        mp_d   = {1'b0, mp_q[WIDTH-1:1]};
      end
    endcase
    fin_res = (op_q == ALU_MUL) ? acc_d : sh_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= ALU_FWD;
      sh_q     <= '0;
      mp_q     <= '0;
      acc_q    <= '0;
      cbit_q   <= 1'b0;
      lost_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          sh_q   <= sh_d;
          mp_q   <= mp_d;
          acc_q  <= acc_d;
          cbit_q <= cbit_d;
          lost_q <= lost_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q  <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
            carry_q  <= cbit_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            if (iter_op) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              op_q    <= aluop_i;
              cnt_q   <= load_cnt;
              sh_q    <= operand1_i;
              mp_q    <= operand2_i;
              acc_q   <= '0;
              cbit_q  <= 1'b0;
              lost_q  <= 1'b0;
            end else begin
              state_q  <= ST_FIN;
              done_q   <= 1'b1;
              result_q <= core_res;
              zero_q   <= (core_res == '0);
              carry_q  <= core_carry;
            end
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aluresult_o = result_q;
  assign zero_o      = zero_q;
  assign carry_o     = carry_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8): latency-level reference model checked
// every cycle, plus directed scenarios with hand-computed expected values.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [2:0]   aluop = ALU_FWD;
  logic         busy_o, done_o, zero_o, carry_o;
  logic [W-1:0] aluresult_o;

  int errors = 0;
  int checks = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .operand1_i  (op1),
    .operand2_i  (op2),
    .aluop_i     (aluop),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aluresult_o (aluresult_o),
    .zero_o      (zero_o),
    .carry_o     (carry_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op definitions.
  function automatic int ref_n(input logic [W-1:0] b);
    return (int'(b) > W) ? W : int'(b);
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op == ALU_MUL) return W + 1;
    if (op == ALU_SLL || op == ALU_SRA) return ref_n(b) + 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int n  = ref_n(b);
    int sa = a[W-1] ? ia - (1 << W) : ia;
    int r;
    case (op)
      ALU_FWD: r = ib;
      ALU_ADD: r = ia + ib;
      ALU_AND: r = ia & ib;
      ALU_OR:  r = ia | ib;
      ALU_SUB: r = ia - ib;
      ALU_SLL: r = ia << n;
      ALU_SRA: r = sa >>> n;
      default: r = ia * ib;
    endcase
    r = r & MASK;
    return W'(r);
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int n  = ref_n(b);
    case (op)
      ALU_ADD: return (ia + ib) > MASK;
      ALU_SUB: return ia < ib;
      ALU_SLL: return (n == 0) ? 1'b0 : (((ia >> (W - n)) & 1) == 1);
      ALU_SRA: return (n == 0) ? 1'b0 : (((ia >> (n - 1)) & 1) == 1);
      ALU_MUL: return (ia * ib) > MASK;
      default: return 1'b0;
    endcase
  endfunction

  // Model: an accepted op publishes its result ref_lat edges later; START is ignored meanwhile.
  int           m_rem = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_zero = 1'b0;
  logic         m_carry = 1'b0;
  logic [W-1:0] p_res = '0;
  logic         p_carry = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem   <= 0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_carry <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done  <= 1'b1;
        m_res   <= p_res;
        m_zero  <= (p_res == '0);
        m_carry <= p_carry;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (ref_lat(aluop, op2) == 1) begin
          m_done  <= 1'b1;
          m_res   <= ref_res(aluop, op1, op2);
          m_zero  <= (ref_res(aluop, op1, op2) == '0);
          m_carry <= ref_carry(aluop, op1, op2);
        end else begin
          m_rem   <= ref_lat(aluop, op2) - 1;
          p_res   <= ref_res(aluop, op1, op2);
          p_carry <= ref_carry(aluop, op1, op2);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model busy", busy_o, (m_rem > 0));
    chk("model done", done_o, m_done);
    chk("model result", aluresult_o, m_res);
    chk("model zero", zero_o, m_zero);
    chk("model carry", carry_o, m_carry);
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_res,
                        input logic exp_c, input logic exp_z);
    int cyc = 1;
    int nbusy = 0;
    @(negedge clk);
    start = 1'b1; aluop = op; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0;
    while (!done_o && cyc < 40) begin
      if (busy_o) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({name, " done"}, done_o, 1'b1);
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " busy cycles"}, nbusy, exp_lat - 1);
    chk({name, " result"}, aluresult_o, exp_res);
    chk({name, " carry"}, carry_o, exp_c);
    chk({name, " zero"}, zero_o, exp_z);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset result", aluresult_o, 8'h00);
    chk("reset busy", busy_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    rst_n = 1'b1;

    run_op("add0f_f0", ALU_ADD, 8'h0F, 8'hF0, 1, 8'hFF, 1'b0, 1'b0);
    run_op("add80_80", ALU_ADD, 8'h80, 8'h80, 1, 8'h00, 1'b1, 1'b1);
    run_op("sub05_07", ALU_SUB, 8'h05, 8'h07, 1, 8'hFE, 1'b1, 1'b0);
    run_op("fwd_ab",   ALU_FWD, 8'h12, 8'hAB, 1, 8'hAB, 1'b0, 1'b0);
    run_op("mul0c_0b", ALU_MUL, 8'h0C, 8'h0B, 9, 8'h84, 1'b0, 1'b0);
    run_op("mul10_10", ALU_MUL, 8'h10, 8'h10, 9, 8'h00, 1'b1, 1'b1);
    run_op("sra90_3",  ALU_SRA, 8'h90, 8'd3,  4, 8'hF2, 1'b0, 1'b0);
    run_op("sll81_1",  ALU_SLL, 8'h81, 8'd1,  2, 8'h02, 1'b1, 1'b0);
    run_op("sll_by0",  ALU_SLL, 8'h5A, 8'd0,  1, 8'h5A, 1'b0, 1'b0);
    run_op("sll_by12", ALU_SLL, 8'h5B, 8'd12, 9, 8'h00, 1'b1, 1'b1);

    // START during a MUL must be dropped.
    @(negedge clk);
    start = 1'b1; aluop = ALU_MUL; op1 = 8'h0C; op2 = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; aluop = ALU_ADD; op1 = 8'h01; op2 = 8'h01;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!done_o && n < 20) begin @(negedge clk); n++; end
      chk("ignored start done", done_o, 1'b1);
      chk("ignored start result", aluresult_o, 8'h84);
    end
    @(negedge clk);
    chk("ignored start no second done", done_o, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    start = 1'b1; aluop = ALU_MUL; op1 = 8'hFF; op2 = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", busy_o, 1'b0);
    chk("midreset done", done_o, 1'b0);
    chk("midreset result", aluresult_o, 8'h00);
    chk("midreset zero", zero_o, 1'b0);
    chk("midreset carry", carry_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add1_1", ALU_ADD, 8'h01, 8'h01, 1, 8'h02, 1'b0, 1'b0);

    // Back-to-back one-cycle ops keep DONE high.
    @(negedge clk);
    start = 1'b1; aluop = ALU_ADD; op1 = 8'h0F; op2 = 8'hF0;
    @(negedge clk);
    chk("b2b add done", done_o, 1'b1);
    chk("b2b add result", aluresult_o, 8'hFF);
    aluop = ALU_AND; op1 = 8'h0F; op2 = 8'hF0;
    @(negedge clk);
    chk("b2b and done", done_o, 1'b1);
    chk("b2b and result", aluresult_o, 8'h00);
    chk("b2b and zero", zero_o, 1'b1);
    aluop = ALU_OR; op1 = 8'h8F; op2 = 8'hB0;
    @(negedge clk);
    chk("b2b or done", done_o, 1'b1);
    chk("b2b or result", aluresult_o, 8'hBF);
    start = 1'b0;

    // Random traffic, including STARTs while busy; the per-cycle model does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      aluop = 3'($urandom_range(0, 7));
      op1   = 8'($urandom);
      op2   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, clocked successor to the single-cycle 8-bit ALU. It adds SUB, shift and multiply operations, a START/BUSY/DONE handshake, and registered ZERO/CARRY flags. FORWARD/ADD/AND/OR/SUB complete in one cycle. Shifts and MUL iterate one bit per cycle, so the datapath stays narrow at any WIDTH. It sits between the register file and write-back, and the control unit stalls on BUSY.

## Interface
- WIDTH, 8: operand and result width; any value ≥ 2.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- OPERAND1  in  WIDTH  first operand (A).
- OPERAND2  in  WIDTH  second operand (B) or shift amount.
- ALUOP  in  3  operation select.
- BUSY  out  1  iterative operation in progress.
- DONE  out  1  one-cycle pulse: result and flags valid.
- ALURESULT  out  WIDTH  registered result, held until the next completion.
- ZERO  out  1  registered, ALURESULT==0.
- CARRY  out  1  registered, operation-specific (see Operation).

## Operation
- The op code is ALUOP; A is OPERAND1 and B is OPERAND2. All arithmetic is modulo 2^WIDTH.
- 000 FORWARD: result = B. CARRY = 0. One cycle.
- 001 ADD: result = A+B. CARRY = carry-out. One cycle.
- 010 AND: result = A&B. CARRY = 0. One cycle.
- 011 OR: result = A|B. CARRY = 0. One cycle.
- 100 SUB: result = A−B. CARRY = borrow (A<B unsigned). One cycle.
- 101 SLL: result = A<<n. CARRY = last bit shifted out. Iterative.
- 110 SRA: result = A>>>n (arithmetic). CARRY = last bit shifted out. Iterative.
- 111 MUL: result = low WIDTH bits of A*B (unsigned shift-add). CARRY = 1 if the high half is nonzero. Iterative.
- Shift count n = min(B, WIDTH). If n=0, the shift behaves as a one-cycle op with result = A and CARRY = 0.
- A, B and ALUOP are captured at the accepting edge. Later input changes have no effect on an op in flight.
- FSM states: IDLE, RUN, FIN.
  - IDLE/FIN with START=1 and a one-cycle op: go to FIN; result and flags are written on this edge.
  - IDLE/FIN with START=1 and an iterative op: go to RUN; load operands; counter = n, or WIDTH for MUL.
  - IDLE/FIN with START=0: go to IDLE.
  - RUN: one step per edge and counter−1. On the step that takes the counter to 0, write result and flags and go to FIN.
- Outputs: BUSY = (state==RUN). DONE = (state==FIN).
- START while BUSY=1 is ignored; there is no queueing.
- ALURESULT, ZERO and CARRY update only on completion.

## Timing
- Reset values: ALURESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0, state IDLE, counter 0.
- Reset takes effect immediately, including mid-operation; the partial result is discarded.
- Take the accepting edge as k.
  - One-cycle op: DONE is high in the cycle after edge k (latency 1). BUSY is never asserted.
  - Iterative op with count c: BUSY is high after edges k..k+c−1; DONE is high after edge k+c (latency c+1). MUL at WIDTH=8 has latency 9.
- Back-to-back: START accepted in FIN restarts immediately with no idle cycle. DONE then stays high for one-cycle ops issued every cycle.
- MUL and shift use WIDTH-bit accumulator/shift registers plus a $clog2(WIDTH)+1 bit counter. The MUL carry detect uses a sticky overflow bit set whenever accumulated partial products exceed WIDTH bits.

## Structure
- Package alu_pkg holds the ALUOP encodings as localparams (ALU_FWD … ALU_MUL) and the FSM state encoding.
- Sub-module alu_core (combinational) holds FORWARD/ADD/AND/OR/SUB with carry/borrow.
- The multicycle_alu top holds the FSM, counter, iterative shift/multiply datapath and output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD 0x0F+0xF0 → 0xFF, CARRY=0, ZERO=0. DONE one cycle after START; BUSY stays 0.
- ADD 0x80+0x80 → 0x00, CARRY=1, ZERO=1. SUB 0x05−0x07 → 0xFE, CARRY=1. FORWARD B=0xAB → 0xAB.
- MUL 0x0C*0x0B → 0x84, CARRY=0. BUSY for 8 cycles, DONE at cycle 9. MUL 0x10*0x10 → 0x00, CARRY=1, ZERO=1.
- SRA 0x90 by 3 → 0xF2, CARRY=0, DONE at cycle 4. SLL 0x81 by 1 → 0x02, CARRY=1. SLL by 0 → A with latency 1. SLL by 12 → 0x00 after 8 steps.
- START with a new op while MUL is BUSY is ignored, and the MUL result is unchanged. Asserting RESET low mid-MUL forces all outputs to 0 immediately; after release, ADD 1+1 → 0x02.
- Issue ADD, AND and OR on consecutive cycles → three DONE cycles in a row with the correct results 0xFF, 0x00 and 0xBF (operands 0x8F/0xB0 for OR).
